// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants and check-node expander state encoding.
// Default widths match the layered min-sum datapath.
package ldpc_pkg;

    localparam int NOB     = 4;
    localparam int MAX_DEG = 19;
    localparam int IW      = 5;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/cn_msg_select.sv
// Per-edge check-to-variable message: min1/min2 pick, offset with
// saturation at zero, and extrinsic sign.
module cn_msg_select #(
    parameter int           NOB    = 4,
    parameter logic [NOB:0] OFFSET = '0
) (
    input  logic [NOB:0]             min1,
    input  logic [NOB:0]             min2,
    input  logic [ldpc_pkg::IW-1:0]  idx,
    input  logic [ldpc_pkg::IW-1:0]  edge_idx,
    input  logic                     tsgn,
    input  logic                     esgn,
    output logic                     sign,
    output logic [NOB:0]             mag
);

    logic [NOB:0] sel;

    // The min1 edge must not see its own magnitude, so it gets min2.
    assign sel  = (edge_idx == idx) ? min2 : min1;
    assign mag  = (sel > OFFSET) ? sel - OFFSET : '0;
    assign sign = tsgn ^ esgn;

endmodule

// File: rtl/cn_msg_expander.sv
// Expands a compressed check-node record (min1, min2, idx, signs)
// into one check-to-variable message per edge over a valid/ready stream.
module cn_msg_expander #(
    parameter int           NOB     = ldpc_pkg::NOB,
    parameter int           MAX_DEG = ldpc_pkg::MAX_DEG,
    parameter logic [NOB:0] OFFSET  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NOB:0]       in_min1,
    input  logic [NOB:0]       in_min2,
    input  logic [4:0]         in_idx,
    input  logic [MAX_DEG-1:0] in_sgn,
    input  logic [4:0]         in_deg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_edge,
    output logic               out_sign,
    output logic [NOB:0]       out_mag,
    output logic               out_last,
    output logic               err
);

    import ldpc_pkg::*;

    state_t             state, state_nxt;
    logic [NOB:0]       min1_q, min2_q;
    logic [IW-1:0]      idx_q, deg_q, edge_q, edge_nxt;
    logic [MAX_DEG-1:0] sgn_q;
    logic [31:0]        sgn_x;
    logic               tsgn_q, tsgn_in, err_q;
    logic               legal, accept, load, beat;

    assign legal = (in_deg >= IW'(2)) && (in_deg <= IW'(MAX_DEG));

    assign out_valid = (state == STREAM);
    assign out_last  = out_valid && (edge_q == deg_q - IW'(1));
    assign beat      = out_valid & out_ready;
    assign in_ready  = (state == IDLE) || (beat && out_last);
    assign accept    = in_valid & in_ready;
    assign load      = accept & legal;
    assign out_edge  = edge_q;
    assign err       = err_q;
    assign sgn_x     = 32'(sgn_q);

    // Parity over the row's live edges only; upper sign bits are don't-care.
    always_comb begin
        tsgn_in = 1'b0;
        for (int i = 0; i < MAX_DEG; i++) begin
            if (i < int'(in_deg))
                tsgn_in = tsgn_in ^ in_sgn[i];
        end
    end

    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_q;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = STREAM;
                    edge_nxt  = '0;
                end
            end
            STREAM: begin
                if (beat) begin
                    if (out_last) begin
                        state_nxt = load ? STREAM : IDLE;
                        edge_nxt  = '0;
                    end else begin
                        edge_nxt = edge_q + IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            edge_q <= '0;
            err_q  <= 1'b0;
            min1_q <= '0;
            min2_q <= '0;
            idx_q  <= '0;
            deg_q  <= '0;
            sgn_q  <= '0;
            tsgn_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            edge_q <= edge_nxt;
            err_q  <= accept & ~legal;
            if (load) begin
                min1_q <= in_min1;
                min2_q <= in_min2;
                idx_q  <= in_idx;
                deg_q  <= in_deg;
                sgn_q  <= in_sgn;
                tsgn_q <= tsgn_in;
            end
        end
    end

    cn_msg_select #(
        .NOB    (NOB),
        .OFFSET (OFFSET)
    ) u_sel (
        .min1     (min1_q),
        .min2     (min2_q),
        .idx      (idx_q),
        .edge_idx (edge_q),
        .tsgn     (tsgn_q),
        .esgn     (sgn_x[edge_q]),
        .sign     (out_sign),
        .mag      (out_mag)
    );

endmodule

// File: tb/tb_cn_msg_expander.sv
// Bench for cn_msg_expander: vector table, corner sequences and a
// randomized run against a queue-based reference model (OFFSET 0 and 2).
module tb_cn_msg_expander;

    localparam int NOB = 4;
    localparam int MD  = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid, out_ready;
    logic [NOB:0]  in_min1, in_min2;
    logic [4:0]    in_idx, in_deg;
    logic [MD-1:0] in_sgn;

    logic          in_ready, out_valid, out_sign, out_last, err;
    logic [4:0]    out_edge;
    logic [NOB:0]  out_mag;
    logic          in_ready2, out_valid2, out_sign2, out_last2, err2;
    logic [4:0]    out_edge2;
    logic [NOB:0]  out_mag2;

    always #5 clk = ~clk;

    cn_msg_expander #(.NOB(NOB), .MAX_DEG(MD), .OFFSET(5'd0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx),
        .in_sgn(in_sgn), .in_deg(in_deg), .out_valid(out_valid),
        .out_ready(out_ready), .out_edge(out_edge), .out_sign(out_sign),
        .out_mag(out_mag), .out_last(out_last), .err(err)
    );

    cn_msg_expander #(.NOB(NOB), .MAX_DEG(MD), .OFFSET(5'd2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx),
        .in_sgn(in_sgn), .in_deg(in_deg), .out_valid(out_valid2),
        .out_ready(out_ready), .out_edge(out_edge2), .out_sign(out_sign2),
        .out_mag(out_mag2), .out_last(out_last2), .err(err2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0] edge_n;
        logic       sign;
        logic [4:0] mag0;
        logic [4:0] mag2;
        logic       last;
    } beat_t;

    beat_t q[$];
    logic  err_pend = 1'b0;

    task automatic model_push(input logic [4:0] m1, input logic [4:0] m2,
                              input logic [4:0] idx, input logic [4:0] deg,
                              input logic [MD-1:0] sgn);
        logic  tot = 1'b0;
        int    sel;
        beat_t b;
        for (int i = 0; i < int'(deg); i++) tot ^= sgn[i];
        for (int e = 0; e < int'(deg); e++) begin
            sel      = (e == int'(idx)) ? int'(m2) : int'(m1);
            b.edge_n = 5'(e);
            b.sign   = tot ^ sgn[e];
            b.mag0   = 5'(sel);
            b.mag2   = (sel > 2) ? 5'(sel - 2) : 5'd0;
            b.last   = (e == int'(deg) - 1);
            q.push_back(b);
        end
    endtask

    // Reference-model monitor: every negedge checks handshake and beat data.
    always @(negedge clk) begin
        logic  exp_rdy;
        beat_t b;
        if (rst) begin
            q.delete();
            err_pend = 1'b0;
        end else begin
            exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1);
            chk("mon_valid", out_valid, q.size() != 0);
            chk("mon_ready", in_ready, exp_rdy);
            chk("mon_err", err, err_pend);
            chk("mon_err2", err2, err_pend);
            if (out_valid && q.size() != 0) begin
                b = q[0];
                chk("mon_edge", out_edge, b.edge_n);
                chk("mon_sign", out_sign, b.sign);
                chk("mon_mag0", out_mag, b.mag0);
                chk("mon_mag2", out_mag2, b.mag2);
                chk("mon_last", out_last, b.last);
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            err_pend = 1'b0;
            if (in_valid && exp_rdy) begin
                if (in_deg >= 5'd2 && in_deg <= 5'(MD))
                    model_push(in_min1, in_min2, in_idx, in_deg, in_sgn);
                else
                    err_pend = 1'b1;
            end
        end
    end

    typedef struct {
        logic [4:0]      m1, m2, idx, deg;
        logic [MD-1:0]   sgn;
        logic            err;
        logic [3:0][4:0] mag0;
        logic [3:0][4:0] mag2;
        logic [3:0]      sign;
    } vec_t;

    vec_t tab[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_min1 = v.m1;
        in_min2 = v.m2;
        in_idx  = v.idx;
        in_deg  = v.deg;
        in_sgn  = v.sgn;
    endtask

    initial begin
        vec_t v;
        logic found;

        tab[0] = '{m1:5'd3, m2:5'd7, idx:5'd2, deg:5'd4, sgn:19'h6, err:1'b0,
                   mag0:{5'd3, 5'd7, 5'd3, 5'd3}, mag2:{5'd1, 5'd5, 5'd1, 5'd1},
                   sign:4'b0110};
        tab[1] = '{m1:5'd1, m2:5'd5, idx:5'd0, deg:5'd2, sgn:19'h0, err:1'b0,
                   mag0:{5'd0, 5'd0, 5'd1, 5'd5}, mag2:{5'd0, 5'd0, 5'd0, 5'd3},
                   sign:4'b0000};
        tab[2] = '{m1:5'd4, m2:5'd9, idx:5'd5, deg:5'd3, sgn:19'h7FFF9, err:1'b0,
                   mag0:{5'd0, 5'd4, 5'd4, 5'd4}, mag2:{5'd0, 5'd2, 5'd2, 5'd2},
                   sign:4'b0110};
        tab[3] = '{m1:5'd10, m2:5'd2, idx:5'd1, deg:5'd2, sgn:19'h1, err:1'b0,
                   mag0:{5'd0, 5'd0, 5'd2, 5'd10}, mag2:{5'd0, 5'd0, 5'd0, 5'd8},
                   sign:4'b0010};
        tab[4] = '{m1:5'd3, m2:5'd4, idx:5'd0, deg:5'd1, sgn:19'h1, err:1'b1,
                   mag0:'0, mag2:'0, sign:'0};
        tab[5] = '{m1:5'd3, m2:5'd4, idx:5'd0, deg:5'd20, sgn:19'h1, err:1'b1,
                   mag0:'0, mag2:'0, sign:'0};

        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_min1   = '0;
        in_min2   = '0;
        in_idx    = '0;
        in_deg    = '0;
        in_sgn    = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_edge", out_edge, 0);
        chk("rst_sign", out_sign, 0);
        chk("rst_mag", out_mag, 0);
        chk("rst_mag2", out_mag2, 0);
        chk("rst_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            v = tab[i];
            drive(v);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (v.err) begin
                chk("tab_err", err, 1);
                chk("tab_noval", out_valid, 0);
                chk("tab_rdy", in_ready, 1);
                step();
                chk("tab_err_clr", err, 0);
                chk("tab_noval2", out_valid, 0);
            end else begin
                for (int e = 0; e < int'(v.deg); e++) begin
                    chk("tab_valid", out_valid, 1);
                    chk("tab_edge", out_edge, 5'(e));
                    chk("tab_sign", out_sign, v.sign[e]);
                    chk("tab_mag0", out_mag, v.mag0[e]);
                    chk("tab_mag2", out_mag2, v.mag2[e]);
                    chk("tab_last", out_last, e == int'(v.deg) - 1);
                    step();
                end
                chk("tab_idle", out_valid, 0);
            end
        end

        // Back-pressure on edge 1 for three cycles.
        drive(tab[0]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_edge0", out_edge, 0);
        step();
        chk("bp_edge1", out_edge, 1);
        out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp_hold_edge", out_edge, 1);
            chk("bp_hold_mag", out_mag, 3);
            chk("bp_hold_sign", out_sign, 1);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_edge2", out_edge, 2);
        chk("bp_mag2", out_mag, 7);
        step();
        chk("bp_edge3", out_edge, 3);
        chk("bp_last", out_last, 1);
        step();
        chk("bp_idle", out_valid, 0);

        // Back-to-back records with in_valid held.
        drive(tab[0]);
        in_valid = 1'b1;
        step();
        drive(tab[1]);
        for (int c = 0; c < 4; c++) begin
            chk("b2b_rdy", in_ready, c == 3);
            chk("b2b_edge", out_edge, 5'(c));
            step();
        end
        in_valid = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_new_edge0", out_edge, 0);
        chk("b2b_new_mag", out_mag, 5);
        step();
        chk("b2b_new_last", out_last, 1);
        step();
        chk("b2b_idle", out_valid, 0);

        // Reset in the middle of a degree-6 record.
        in_min1  = 5'd2;
        in_min2  = 5'd6;
        in_idx   = 5'd3;
        in_deg   = 5'd6;
        in_sgn   = 19'h2D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_edge == 5'd2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rst_reach_edge2", found, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_edge", out_edge, 0);
        chk("rst_mid_last", out_last, 0);
        step();
        step();
        rst = 1'b0;
        chk("rst_rel_ready", in_ready, 1);
        step();
        chk("rst_no_resume", out_valid, 0);
        drive(tab[1]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rst_new_valid", out_valid, 1);
        chk("rst_new_edge", out_edge, 0);
        chk("rst_new_mag", out_mag, 5);
        step();
        step();
        chk("rst_new_idle", out_valid, 0);

        // Randomized traffic; the monitor checks every cycle.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_min1   = 5'($urandom);
            in_min2   = 5'($urandom);
            in_idx    = 5'($urandom_range(0, MD + 2));
            in_sgn    = 19'($urandom);
            in_deg    = ($urandom_range(0, 9) == 0) ? 5'($urandom)
                                                    : 5'($urandom_range(2, MD));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && out_valid; c++) step();
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cn_msg_expander.md
CN_MSG_EXPANDER -- requirements
Module: cn_msg_expander

Interface
REQ-001 Parameter NOB, default 4, magnitude MSB index; magnitudes are NOB+1 bits.
REQ-002 Parameter MAX_DEG, default 19, maximum check-node row degree.
REQ-003 Parameter OFFSET, default 0, offset-min-sum subtrahend, NOB+1 bits.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port in_valid, input, 1, compressed check-node record present.
REQ-007 Port in_ready, output, 1, block can accept a record this cycle.
REQ-008 Port in_min1, input, NOB+1, smallest row magnitude.
REQ-009 Port in_min2, input, NOB+1, second-smallest row magnitude.
REQ-010 Port in_idx, input, 5, edge position of min1.
REQ-011 Port in_sgn, input, MAX_DEG, per-edge variable-to-check sign bits; bit e = edge e.
REQ-012 Port in_deg, input, 5, row degree for this record.
REQ-013 Port out_valid, output, 1, check-to-variable message present.
REQ-014 Port out_ready, input, 1, downstream accepts message.
REQ-015 Port out_edge, output, 5, edge index of current message.
REQ-016 Port out_sign, output, 1, message sign (1 = negative).
REQ-017 Port out_mag, output, NOB+1, message magnitude.
REQ-018 Port out_last, output, 1, high on final edge of record.
REQ-019 Port err, output, 1, one-cycle pulse on illegal degree.

Function
REQ-020 Two states: IDLE, STREAM.
REQ-021 in_ready SHALL be 1 in IDLE, and in STREAM only when out_valid & out_ready & out_last (back-to-back accept).
REQ-022 Record captured on in_valid & in_ready; all in_* fields registered together.
REQ-023 Legal in_deg range 2..MAX_DEG; illegal degree: record consumed, err=1 next cycle, no output beats, state IDLE.
REQ-024 Legal record: next cycle STREAM, out_valid=1, out_edge=0.
REQ-025 Beat advances only on out_valid & out_ready; out_* held stable while out_ready=0.
REQ-026 Edge counter increments 0..deg-1; out_last = (out_edge == deg-1).
REQ-027 Last beat accepted with no new record: IDLE, out_valid=0 next cycle.
REQ-028 Last beat accepted with new record captured same cycle: stay STREAM, out_edge=0 of new record next cycle, no bubble.
REQ-029 Selected magnitude = min2 when out_edge == idx, else min1.
REQ-030 out_mag = selected - OFFSET, saturating at 0; no wrap.
REQ-031 Total sign = XOR of in_sgn[deg-1:0], computed once at capture; bits >= deg ignored.
REQ-032 out_sign = total sign XOR sgn[out_edge].
REQ-033 in_idx >= deg: every edge receives min1; no error.
REQ-034 min2 < min1 not checked; values used as given.
REQ-035 Latency: first beat one cycle after capture; throughput one beat per cycle without back-pressure.

Reset
REQ-036 rst asserted at any time: state IDLE, out_valid=0, out_last=0, err=0, out_edge=0, out_sign=0, out_mag=0, all record registers 0, in_ready=1 after release.
REQ-037 Record in flight at reset is discarded; no beats resume after release.

Structure
REQ-038 Shared package ldpc_pkg holds NOB, MAX_DEG, index width 5, state encoding.
REQ-039 One combinational sub-module cn_msg_select: (min1, min2, idx, edge, total sign, edge sign) -> (sign, offset-saturated magnitude).

Verification
REQ-040 OFFSET=0, min1=3, min2=7, idx=2, deg=4, sgn=4'b0110, out_ready=1 -> edges 0..3 mag 3,3,7,3, sign 0,1,1,0, out_last on edge 3 only, 4 consecutive cycles.
REQ-041 Same record, out_ready low on edge 1 for 3 cycles -> edge 1 values held, no edge skipped or repeated.
REQ-042 Two records back-to-back, in_valid held -> second record edge 0 on cycle after first record's last beat; in_ready high only on that last-beat cycle.
REQ-043 OFFSET=2, min1=1, min2=5, idx=0, deg=2 -> mags 3,0 (saturated).
REQ-044 in_deg=1 then in_deg=20 -> err pulse each, no out_valid, in_ready stays 1.
REQ-045 rst asserted at edge 2 of deg-6 record -> out_valid=0 immediately, IDLE after release, next record starts at edge 0.
